// File: rtl/outlayer_seq_if.sv
// Bus between the output-layer sequencer and the shared neuron/weight ROM.
// The master issues rows and activations; the slave returns one score per row.
interface outlayer_seq_if #(
    parameter int W = 8
);
    logic [W-1:0] neu_in1;
    logic [W-1:0] neu_in2;
    logic [W-1:0] neu_in3;
    logic [W-1:0] neu_in4;
    logic [4:0]   rom_addr;
    logic         rom_en;
    logic [W-1:0] score;

    modport master (
        output neu_in1, neu_in2, neu_in3, neu_in4, rom_addr, rom_en,
        input  score
    );

    modport slave (
        input  neu_in1, neu_in2, neu_in3, neu_in4, rom_addr, rom_en,
        output score
    );
endinterface

// File: rtl/outlayer_seq.sv
// Time-multiplexed Morse output layer: walks all class rows through one shared
// neuron and keeps a running unsigned max/argmax (ties keep the lower index).
module outlayer_seq #(
    parameter int NUM_CLASSES = 26,
    parameter int BASE_ADDR   = 4,
    parameter int LAT         = 1,
    parameter int W           = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [W-1:0]   in1,
    input  logic [W-1:0]   in2,
    input  logic [W-1:0]   in3,
    input  logic [W-1:0]   in4,
    outlayer_seq_if.master nbus,
    output logic           busy,
    output logic           done,
    output logic [4:0]     out,
    output logic [W-1:0]   maxval
);
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [4:0] N_CLS = 5'(NUM_CLASSES);
    localparam logic [4:0] BASE  = 5'(BASE_ADDR);

    state_t         r_state, w_state_n;
    logic [4:0]     r_issue_cnt, w_issue_cnt_n;
    logic [4:0]     r_rcv_cnt, w_rcv_cnt_n;
    logic [LAT-1:0] r_vpipe, w_vpipe_n;
    logic [W-1:0]   r_run_max, w_run_max_n;
    logic [4:0]     r_run_idx, w_run_idx_n;
    logic [W-1:0]   r_neu1, r_neu2, r_neu3, r_neu4;
    logic [W-1:0]   w_neu1_n, w_neu2_n, w_neu3_n, w_neu4_n;
    logic [4:0]     r_rom_addr, w_rom_addr_n;
    logic           r_rom_en, w_rom_en_n;
    logic           r_busy, w_busy_n;
    logic           r_done, w_done_n;
    logic [4:0]     r_out, w_out_n;
    logic [W-1:0]   r_maxval, w_maxval_n;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_n;
        end
    end

    // Datapath and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_issue_cnt <= 5'd0;
            r_rcv_cnt   <= 5'd0;
            r_vpipe     <= '0;
            r_run_max   <= '0;
            r_run_idx   <= 5'd0;
            r_neu1      <= '0;
            r_neu2      <= '0;
            r_neu3      <= '0;
            r_neu4      <= '0;
            r_rom_addr  <= 5'd0;
            r_rom_en    <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_out       <= 5'd0;
            r_maxval    <= '0;
        end else begin
            r_issue_cnt <= w_issue_cnt_n;
            r_rcv_cnt   <= w_rcv_cnt_n;
            r_vpipe     <= w_vpipe_n;
            r_run_max   <= w_run_max_n;
            r_run_idx   <= w_run_idx_n;
            r_neu1      <= w_neu1_n;
            r_neu2      <= w_neu2_n;
            r_neu3      <= w_neu3_n;
            r_neu4      <= w_neu4_n;
            r_rom_addr  <= w_rom_addr_n;
            r_rom_en    <= w_rom_en_n;
            r_busy      <= w_busy_n;
            r_done      <= w_done_n;
            r_out       <= w_out_n;
            r_maxval    <= w_maxval_n;
        end
    end

    // Next-state, score capture and issue sequencing
    always_comb begin
        w_state_n     = r_state;
        w_issue_cnt_n = r_issue_cnt;
        w_rcv_cnt_n   = r_rcv_cnt;
        w_run_max_n   = r_run_max;
        w_run_idx_n   = r_run_idx;
        w_neu1_n      = r_neu1;
        w_neu2_n      = r_neu2;
        w_neu3_n      = r_neu3;
        w_neu4_n      = r_neu4;
        w_rom_addr_n  = r_rom_addr;
        w_rom_en_n    = r_rom_en;
        w_busy_n      = r_busy;
        w_done_n      = 1'b0;
        w_out_n       = r_out;
        w_maxval_n    = r_maxval;

        // rom_en delayed by LAT marks which cycles carry a valid score
        w_vpipe_n    = '0;
        w_vpipe_n[0] = r_rom_en;
        for (int i = 1; i < LAT; i++) begin
            w_vpipe_n[i] = r_vpipe[i-1];
        end

        if (r_vpipe[LAT-1]) begin
            w_rcv_cnt_n = r_rcv_cnt + 5'd1;
            if (nbus.score > r_run_max) begin
                w_run_max_n = nbus.score;
                w_run_idx_n = r_rcv_cnt;
            end else begin
                w_run_max_n = r_run_max;
            end
        end else begin
            w_rcv_cnt_n = r_rcv_cnt;
        end

        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_n     = S_ISSUE;
                    w_neu1_n      = in1;
                    w_neu2_n      = in2;
                    w_neu3_n      = in3;
                    w_neu4_n      = in4;
                    w_run_max_n   = '0;
                    w_run_idx_n   = 5'd0;
                    w_rcv_cnt_n   = 5'd0;
                    w_rom_addr_n  = BASE;
                    w_rom_en_n    = 1'b1;
                    w_issue_cnt_n = 5'd1;
                    w_busy_n      = 1'b1;
                end else begin
                    w_state_n = S_IDLE;
                end
            end
            S_ISSUE: begin
                if (r_issue_cnt == N_CLS) begin
                    w_state_n  = S_DRAIN;
                    w_rom_en_n = 1'b0;
                end else begin
                    w_rom_addr_n  = BASE + r_issue_cnt;
                    w_rom_en_n    = 1'b1;
                    w_issue_cnt_n = r_issue_cnt + 5'd1;
                end
            end
            S_DRAIN: begin
                if (r_rcv_cnt == N_CLS) begin
                    w_state_n  = S_DONE;
                    w_out_n    = r_run_idx;
                    w_maxval_n = r_run_max;
                    w_done_n   = 1'b1;
                    w_busy_n   = 1'b0;
                end else begin
                    w_state_n = S_DRAIN;
                end
            end
            S_DONE: begin
                w_state_n = S_IDLE;
            end
            default: begin
                w_state_n = S_IDLE;
            end
        endcase
    end

    assign nbus.neu_in1  = r_neu1;
    assign nbus.neu_in2  = r_neu2;
    assign nbus.neu_in3  = r_neu3;
    assign nbus.neu_in4  = r_neu4;
    assign nbus.rom_addr = r_rom_addr;
    assign nbus.rom_en   = r_rom_en;
    assign busy          = r_busy;
    assign done          = r_done;
    assign out           = r_out;
    assign maxval        = r_maxval;
endmodule

// File: doc/outlayer_seq.md
Name: outlayer_seq

Overview:
- Time-multiplexed sequencer for the Morse output layer.
- Shares a single external neuron instance across all NUM_CLASSES letter rows. For each row it issues a weight-ROM row address and tracks a running maximum and argmax of the returned scores.
- Replaces the fully parallel 26-neuron / comparator-tree output stage.
- Sits between the hidden layer (in1..in4) and the letter decoder (out).

Parameters:
- NUM_CLASSES, 26, number of output classes (letters); index width fixed at 5 bits.
- BASE_ADDR, 4, ROM row holding the weights of class 0; class k uses row BASE_ADDR+k.
- LAT, 1, cycles from rom_addr/rom_en to the matching score on the score input (1..4).
- W, 8, data width of inputs and scores.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- start  in  1  request a classification; sampled only in IDLE
- in1, in2, in3, in4  in  W each  hidden-layer activations; sampled on accepted start
- neu_in1, neu_in2, neu_in3, neu_in4  out  W each  latched activations driven to the shared neuron
- rom_addr  out  5  weight-ROM row select
- rom_en  out  1  high when rom_addr carries a valid class row
- score  in  W  neuron output for the row issued LAT cycles earlier (unsigned)
- busy  out  1  high from the cycle after an accepted start until done
- done  out  1  one-cycle pulse when out/maxval are updated
- out  out  5  argmax class index of the last completed run
- maxval  out  W  winning score of the last completed run

Behaviour:
- Reset values (rst high at a clock edge, from any state): state=IDLE, busy=0, done=0, rom_en=0, rom_addr=0, out=0, maxval=0, neu_in*=0, issue and receive counters=0, LAT-stage valid pipe cleared.
- States:
  - IDLE -> ISSUE on start=1. in1..in4 are latched into neu_in* on the same edge; the running max is cleared to 0 and the running index to 0.
  - ISSUE:
    - rom_en=1, rom_addr=BASE_ADDR+issue_cnt; issue_cnt increments 0..NUM_CLASSES-1, one row per cycle, no bubbles.
    - After issuing the last row -> DRAIN.
  - DRAIN: rom_en=0; wait until all NUM_CLASSES scores have been received -> DONE.
  - DONE: out and maxval are registered from the running max/index; done=1 for exactly this cycle; busy=0 in this cycle; next state is IDLE.
- Valid tracking:
  - An internal LAT-deep shift register carries rom_en.
  - When its output is 1, score belongs to class rcv_cnt; rcv_cnt then increments.
  - The score input is ignored when the pipe output is 0.
- Compare rule: unsigned. Replace when score > running max (strict). Ties keep the lower class index.
- First score: compared against the cleared max of 0. An all-zero run therefore yields out=0, maxval=0.
- Latency, with start accepted at edge 0:
  - rom_en high for edges 1..NUM_CLASSES.
  - Last score received at edge NUM_CLASSES+LAT.
  - done high in the cycle after edge NUM_CLASSES+LAT+1 (edge 28 for the defaults).
- Accepted start: busy rises in the cycle following the accepting edge.
- start while busy or in DONE: ignored, not queued.
- start held high continuously: a new run begins one cycle after each done (back-to-back).
- out/maxval: hold their value between done pulses; they are not disturbed during a run.
- neu_in*: stable for the entire run; changes on in1..in4 during a run have no effect.
- Reset mid-run: aborts immediately, no done pulse, out/maxval return to 0.
- rom_addr: holds its last value while rom_en=0 (don't-care to the ROM).

Test Plan:
- Reset then idle: rst for 2 cycles, start=0 for 10 cycles -> busy=0, done=0, rom_en=0, out=0, maxval=0 throughout.
- Single peak: start with LAT=1; bench model returns score=10 for every row except row 4+7, which returns 200 -> rom_addr walks 4..29, done pulses exactly 28 cycles after the start edge, out=7, maxval=200.
- Tie and order: scores 50 at classes 3 and 20, all others 49 -> out=3, maxval=50. Then make the last class (row 29) 255 -> out=25, maxval=255.
- Latency variants: repeat the single-peak case with LAT=3 -> done at edge 30, out=7. An all-zero score run -> out=0, maxval=0.
- Busy protocol: pulse start again at edges 5 and 27, and change in1..in4 mid-run -> single run only, neu_in* unchanged. With start held high, the second run's first rom_en appears 2 cycles after the first done.
- Reset mid-run: assert rst at edge 12 of a run -> no done pulse, busy=0, out=0, maxval=0. A following start completes normally with the correct argmax.
